// File: rtl/clk_div_gate_array.sv
// Array of NUM_CH glitch-free pulse-swallowing clock dividers sharing one source clock.
// Ratios are reprogrammed over a valid/ready port and switch only at a period boundary.
module clk_div_gate_array #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DIV_W     = 8,
    parameter int unsigned RESET_DIV = 1,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    test_en_i,
    input  logic                    cfg_valid_i,
    output logic                    cfg_ready_o,
    input  logic [CH_W-1:0]         cfg_ch_i,
    input  logic [DIV_W-1:0]        cfg_div_i,
    output logic                    cfg_err_o,
    output logic                    busy_o,
    output logic [NUM_CH*DIV_W-1:0] div_o,
    output logic [NUM_CH-1:0]       tick_o,
    output logic [NUM_CH-1:0]       clk_o
);

    logic [DIV_W-1:0]  r_div      [NUM_CH];
    logic [DIV_W-1:0]  r_cnt      [NUM_CH];
    logic [DIV_W-1:0]  r_pend_div [NUM_CH];
    logic [NUM_CH-1:0] r_en;
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_icg_en;
    logic              r_err;

    logic              w_ready;
    logic              w_ch_ok;
    logic              w_acc;
    logic [NUM_CH-1:0] w_wrap;
    logic [NUM_CH-1:0] w_apply;

    // Out-of-range channels are always ready so the error path cannot deadlock the port.
    always_comb begin
        w_ready = 1'b1;
        w_ch_ok = 1'b0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            if (cfg_ch_i == CH_W'(ch)) begin
                w_ch_ok = 1'b1;
                w_ready = ~r_pend[ch];
            end
        end
    end

    assign w_acc = cfg_valid_i & w_ready;

    always_comb begin
        w_wrap  = '0;
        w_apply = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            w_wrap[ch]  = (r_div[ch] != '0) && (r_cnt[ch] == r_div[ch] - DIV_W'(1));
            w_apply[ch] = r_pend[ch] && ((r_div[ch] == '0) || w_wrap[ch]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                r_div[ch]      <= DIV_W'(RESET_DIV);
                r_cnt[ch]      <= '0;
                r_pend_div[ch] <= '0;
            end
            r_en   <= '0;
            r_pend <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_acc & ~w_ch_ok;
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                // en follows the old ratio even in the apply cycle: the last old pulse survives.
                if (r_div[ch] == '0) begin
                    r_cnt[ch] <= '0;
                    r_en[ch]  <= 1'b0;
                end else begin
                    r_cnt[ch] <= w_wrap[ch] ? '0 : r_cnt[ch] + DIV_W'(1);
                    r_en[ch]  <= w_wrap[ch];
                end
                if (w_apply[ch]) begin
                    r_div[ch]  <= r_pend_div[ch];
                    r_cnt[ch]  <= '0;
                    r_pend[ch] <= 1'b0;
                end else if (w_acc && (cfg_ch_i == CH_W'(ch))) begin
                    r_pend[ch]     <= 1'b1;
                    r_pend_div[ch] <= cfg_div_i;
                end
            end
        end
    end

    // Latch-based clock gate: enable is captured only while clk_i is low.
    always_latch begin
        if (!clk_i) begin
            r_icg_en <= r_en | {NUM_CH{test_en_i}};
        end
    end

    assign clk_o = {NUM_CH{clk_i}} & r_icg_en;

    always_comb begin
        div_o = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            div_o[ch*DIV_W +: DIV_W] = r_div[ch];
        end
    end

    assign cfg_ready_o = w_ready;
    assign cfg_err_o   = r_err;
    assign busy_o      = |r_pend;
    assign tick_o      = r_en;

endmodule

// File: tb/tb_clk_div_gate_array.sv
// Scoreboard bench for clk_div_gate_array (3 channels): a cycle model pushes expected outputs
// per edge; scenario tasks pop and compare, plus fixed-value checks on key behaviours.
module tb_clk_div_gate_array;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        test_en_i = 1'b0;
    logic        cfg_valid_i = 1'b0;
    logic [1:0]  cfg_ch_i = '0;
    logic [7:0]  cfg_div_i = '0;
    logic        cfg_ready_o;
    logic        cfg_err_o;
    logic        busy_o;
    logic [23:0] div_o;
    logic [2:0]  tick_o;
    logic [2:0]  clk_o;

    clk_div_gate_array #(
        .NUM_CH    (3),
        .DIV_W     (8),
        .RESET_DIV (1)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .test_en_i   (test_en_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_ch_i    (cfg_ch_i),
        .cfg_div_i   (cfg_div_i),
        .cfg_err_o   (cfg_err_o),
        .busy_o      (busy_o),
        .div_o       (div_o),
        .tick_o      (tick_o),
        .clk_o       (clk_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [2:0]  tick;
        logic [23:0] div;
        logic        busy;
        logic        err;
        logic [2:0]  clk;
    } obs_t;

    obs_t sb_q[$];
    obs_t got;
    obs_t exp;
    int   n_checks = 0;
    int   n_pass = 0;
    int   pulses0 = 0;

    logic [7:0] m_div [3];
    logic [7:0] m_cnt [3];
    logic [7:0] m_pdiv [3];
    logic [2:0] m_en;
    logic [2:0] m_pend;
    logic       m_err;

    always @(posedge clk_o[0]) pulses0++;

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_div[c]  = 8'd1;
            m_cnt[c]  = 8'd0;
            m_pdiv[c] = 8'd0;
        end
        m_en   = '0;
        m_pend = '0;
        m_err  = 1'b0;
    endtask

    function automatic logic m_ready(input logic [1:0] ch);
        if (ch < 2'd3) return !m_pend[ch];
        return 1'b1;
    endfunction

    task automatic drive(input logic v, input logic [1:0] ch, input logic [7:0] d);
        cfg_valid_i = v;
        cfg_ch_i    = ch;
        cfg_div_i   = d;
    endtask

    // Advance the model by one edge using the inputs now applied, then let the DUT take the edge.
    task automatic step();
        obs_t e;
        logic acc;
        logic bnd;
        logic [7:0] ncnt;
        e.clk = m_en | {3{test_en_i}};
        acc = cfg_valid_i && m_ready(cfg_ch_i);
        for (int c = 0; c < 3; c++) begin
            bnd = (m_div[c] != 8'd0) && (m_cnt[c] == m_div[c] - 8'd1);
            ncnt = (m_div[c] == 8'd0 || bnd) ? 8'd0 : m_cnt[c] + 8'd1;
            if (m_pend[c] && (m_div[c] == 8'd0 || bnd)) begin
                m_div[c]  = m_pdiv[c];
                ncnt      = 8'd0;
                m_pend[c] = 1'b0;
            end else if (acc && cfg_ch_i == 2'(c)) begin
                m_pend[c] = 1'b1;
                m_pdiv[c] = cfg_div_i;
            end
            m_cnt[c] = ncnt;
            m_en[c]  = bnd;
        end
        m_err  = acc && (cfg_ch_i >= 2'd3);
        e.tick = m_en;
        e.div  = {m_div[2], m_div[1], m_div[0]};
        e.busy = |m_pend;
        e.err  = m_err;
        sb_q.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        got = {tick_o, div_o, busy_o, cfg_err_o, clk_o};
        n_checks++;
        if (got !== {3'b000, 24'h010101, 1'b0, 1'b0, 3'b000})
            $display("FAIL reset_state: got %h want %h", got, {3'b000, 24'h010101, 5'b0});
        else n_pass++;
        rst_ni = 1'b1;
        model_reset();
        drive(1'b0, 2'd0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            exp = sb_q.pop_front();
            got = {tick_o, div_o, busy_o, cfg_err_o, clk_o};
            n_checks++;
            if (got !== exp) $display("FAIL reset_release[%0d]: got %h want %h", i, got, exp);
            else n_pass++;
        end
        n_checks++;
        if (clk_o !== 3'b111) $display("FAIL passthru_high: got %b want 111", clk_o);
        else n_pass++;
        #5;
        n_checks++;
        if (clk_o !== 3'b000) $display("FAIL passthru_low: got %b want 000", clk_o);
        else n_pass++;
    endtask

    task automatic test_div4();
        drive(1'b1, 2'd0, 8'd4);
        step();
        drive(1'b0, 2'd0, 8'd0);
        for (int i = 0; i < 104; i++) begin
            if (i == 4) pulses0 = 0;
            if (i > 0) step();
            else begin
                exp = sb_q.pop_front();
                sb_q.push_front(exp);
            end
            exp = sb_q.pop_front();
            got = {tick_o, div_o, busy_o, cfg_err_o, clk_o};
            n_checks++;
            if (got !== exp) $display("FAIL div4_cyc[%0d]: got %h want %h", i, got, exp);
            else n_pass++;
        end
        n_checks++;
        if (pulses0 != 25) $display("FAIL div4_pulses: got %0d want 25", pulses0);
        else n_pass++;
        n_checks++;
        if (div_o[7:0] !== 8'd4) $display("FAIL div4_ratio: got %0d want 4", div_o[7:0]);
        else n_pass++;
    endtask

    task automatic test_reprogram();
        int stalls = 0;
        logic [7:0] hist = '0;
        logic found = 1'b0;
        drive(1'b1, 2'd1, 8'd5);
        step();
        void'(sb_q.pop_front());
        drive(1'b0, 2'd1, 8'd0);
        for (int i = 0; i < 12 && !found; i++) begin
            if (m_div[1] == 8'd5 && m_cnt[1] == 8'd1) found = 1'b1;
            else begin
                step();
                exp = sb_q.pop_front();
                got = {tick_o, div_o, busy_o, cfg_err_o, clk_o};
                n_checks++;
                if (got !== exp) $display("FAIL reprog_sync: got %h want %h", got, exp);
                else n_pass++;
            end
        end
        n_checks++;
        if (!found) $display("FAIL reprog_phase_timeout: got none want cnt=1");
        else n_pass++;
        drive(1'b1, 2'd1, 8'd2);
        #1;
        n_checks++;
        if (cfg_ready_o !== 1'b1) $display("FAIL reprog_accept: got %b want 1", cfg_ready_o);
        else n_pass++;
        step();
        void'(sb_q.pop_front());
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 2'd1, 8'd0);
            #1;
            if (!cfg_ready_o) stalls++;
            n_checks++;
            if (cfg_ready_o !== m_ready(2'd1))
                $display("FAIL reprog_ready[%0d]: got %b want %b", i, cfg_ready_o, m_ready(2'd1));
            else n_pass++;
            step();
            exp = sb_q.pop_front();
            got = {tick_o, div_o, busy_o, cfg_err_o, clk_o};
            n_checks++;
            if (got !== exp) $display("FAIL reprog_cyc[%0d]: got %h want %h", i, got, exp);
            else n_pass++;
            hist[i] = tick_o[1];
        end
        n_checks++;
        if (stalls != 3) $display("FAIL reprog_stall: got %0d want 3", stalls);
        else n_pass++;
        n_checks++;
        if (hist !== 8'b0101_0100) $display("FAIL reprog_ticks: got %b want 01010100", hist);
        else n_pass++;
    endtask

    task automatic test_off_test_en();
        drive(1'b1, 2'd2, 8'd0);
        for (int i = 0; i < 12; i++) begin
            if (i == 6) test_en_i = 1'b1;
            step();
            drive(1'b0, 2'd2, 8'd0);
            exp = sb_q.pop_front();
            got = {tick_o, div_o, busy_o, cfg_err_o, clk_o};
            n_checks++;
            if (got !== exp) $display("FAIL off_te_cyc[%0d]: got %h want %h", i, got, exp);
            else n_pass++;
        end
        n_checks++;
        if (clk_o[2] !== 1'b1 || tick_o[2] !== 1'b0)
            $display("FAIL te_force: got clk=%b tick=%b want clk=1 tick=0", clk_o[2], tick_o[2]);
        else n_pass++;
        test_en_i = 1'b0;
        step();
        void'(sb_q.pop_front());
        step();
        void'(sb_q.pop_front());
        n_checks++;
        if (clk_o[2] !== 1'b0) $display("FAIL off_flat: got %b want 0", clk_o[2]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic done = 1'b0;
        logic [2:0] want_rdy = 3'b101;
        logic [1:0] chs [3] = '{2'd0, 2'd0, 2'd1};
        logic [7:0] dvs [3] = '{8'd3, 8'd6, 8'd2};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, chs[i], dvs[i]);
            #1;
            n_checks++;
            if (cfg_ready_o !== want_rdy[i])
                $display("FAIL b2b_ready[%0d]: got %b want %b", i, cfg_ready_o, want_rdy[i]);
            else n_pass++;
            step();
            exp = sb_q.pop_front();
            got = {tick_o, div_o, busy_o, cfg_err_o, clk_o};
            n_checks++;
            if (got !== exp) $display("FAIL b2b_cyc[%0d]: got %h want %h", i, got, exp);
            else n_pass++;
        end
        for (int i = 0; i < 10 && !done; i++) begin
            drive(1'b1, 2'd0, 8'd6);
            done = m_ready(2'd0);
            step();
            exp = sb_q.pop_front();
            got = {tick_o, div_o, busy_o, cfg_err_o, clk_o};
            n_checks++;
            if (got !== exp) $display("FAIL b2b_retry[%0d]: got %h want %h", i, got, exp);
            else n_pass++;
        end
        n_checks++;
        if (!done) $display("FAIL b2b_retry_timeout: got stalled want accepted");
        else n_pass++;
        drive(1'b1, 2'd3, 8'h55);
        step();
        exp = sb_q.pop_front();
        got = {tick_o, div_o, busy_o, cfg_err_o, clk_o};
        n_checks++;
        if (got !== exp || cfg_err_o !== 1'b1)
            $display("FAIL b2b_err: got %h want %h", got, exp);
        else n_pass++;
        drive(1'b0, 2'd0, 8'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            exp = sb_q.pop_front();
            got = {tick_o, div_o, busy_o, cfg_err_o, clk_o};
            n_checks++;
            if (got !== exp) $display("FAIL b2b_tail[%0d]: got %h want %h", i, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_reset_pending();
        logic found = 1'b0;
        drive(1'b0, 2'd0, 8'd0);
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_div[0] >= 8'd3 && !m_pend[0] && m_cnt[0] == m_div[0] - 8'd1) found = 1'b1;
            else begin
                step();
                void'(sb_q.pop_front());
            end
        end
        n_checks++;
        if (!found) $display("FAIL rstp_boundary_timeout: got none want boundary");
        else n_pass++;
        drive(1'b1, 2'd0, 8'd9);
        step();
        drive(1'b0, 2'd0, 8'd0);
        void'(sb_q.pop_front());
        step();
        exp = sb_q.pop_front();
        got = {tick_o, div_o, busy_o, cfg_err_o, clk_o};
        n_checks++;
        if (got !== exp || got.busy !== 1'b1 || got.clk[0] !== 1'b1)
            $display("FAIL rstp_pre: got %h want %h", got, exp);
        else n_pass++;
        #1 rst_ni = 1'b0;
        #1;
        n_checks++;
        if (clk_o[0] !== 1'b1 || busy_o !== 1'b0 || tick_o !== 3'b000)
            $display("FAIL rstp_inflight: got clk=%b busy=%b tick=%b want 1 0 000",
                     clk_o[0], busy_o, tick_o);
        else n_pass++;
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        n_checks++;
        if (clk_o !== 3'b000 || div_o !== 24'h010101)
            $display("FAIL rstp_held: got clk=%b div=%h want 000 010101", clk_o, div_o);
        else n_pass++;
        rst_ni = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            exp = sb_q.pop_front();
            got = {tick_o, div_o, busy_o, cfg_err_o, clk_o};
            n_checks++;
            if (got !== exp) $display("FAIL rstp_release[%0d]: got %h want %h", i, got, exp);
            else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_div4();
        test_reprogram();
        test_off_test_en();
        test_back_to_back();
        test_reset_pending();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
